// File: rtl/ct_fcnvt_norm_sh_pipe_if.sv
// ---------------------------------------------------------------------------
// ct_fcnvt_norm_sh_pipe_if
//
// Purpose:
//   Handshake bundle for the fcnvt subnormal normaliser. It carries the input
//   side (valid/ready, mode, source fraction, tag) and the output side
//   (valid/ready, normalised fraction, exponent, zero flag, tag).
//
// Parameters (must match the normaliser instance bound to it):
//   FRAC_W  source fraction width; out_f is FRAC_W+1 bits
//   CNT_W   output exponent width (two's complement)
//   TAG_W   sideband tag width
//
// Modports:
//   slave   normaliser view: consumes in_*, produces out_*, reads out_rdy
//   master  environment view: produces in_*, consumes out_*, drives out_rdy
// ---------------------------------------------------------------------------
interface ct_fcnvt_norm_sh_pipe_if #(
    parameter int FRAC_W = 23,
    parameter int CNT_W  = 12,
    parameter int TAG_W  = 4
);
    // Input side
    logic              in_vld;
    logic              in_rdy;
    logic              in_mode;   // 0 = single, 1 = half
    logic [FRAC_W-1:0] in_src;
    logic [TAG_W-1:0]  in_tag;

    // Output side
    logic              out_vld;
    logic              out_rdy;
    logic [FRAC_W:0]   out_f;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_vld,
        input  in_mode,
        input  in_src,
        input  in_tag,
        output in_rdy,
        output out_vld,
        output out_f,
        output out_cnt,
        output out_zero,
        output out_tag,
        input  out_rdy
    );

    modport master (
        output in_vld,
        output in_mode,
        output in_src,
        output in_tag,
        input  in_rdy,
        input  out_vld,
        input  out_f,
        input  out_cnt,
        input  out_zero,
        input  out_tag,
        output out_rdy
    );
endinterface : ct_fcnvt_norm_sh_pipe_if

// File: rtl/ct_fcnvt_norm_sh_pipe.sv
// ---------------------------------------------------------------------------
// ct_fcnvt_norm_sh_pipe
//
// Purpose:
//   Two-stage pipelined subnormal normaliser for the FP convert path.
//   Stage 1 selects the source field (single: all FRAC_W bits, half: the top
//   HLF_W bits) and counts the zeros above its leading one. Stage 2 shifts
//   the leading one up to bit FRAC_W of the result and forms the signed,
//   unbiased exponent -(bias + lz) for the wider destination format.
//   A zero field yields out_f = 0, out_cnt = 0, out_zero = 1.
//
// Ports:
//   forever_cpuclk  clock
//   cpurst          synchronous active-high reset
//   pipe_flush      kills every in-flight entry and any input taken this cycle
//   bus             handshake bundle (slave modport), see the interface file
//
// Timing:
//   Two cycles from acceptance to out_vld, one result per cycle while
//   out_rdy is high. in_rdy is combinational from the stage valids and out_rdy.
// ---------------------------------------------------------------------------
module ct_fcnvt_norm_sh_pipe #(
    parameter int FRAC_W   = 23,
    parameter int HLF_W    = 10,
    parameter int SGL_BIAS = 127,
    parameter int HLF_BIAS = 15,
    parameter int CNT_W    = 12,
    parameter int TAG_W    = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  pipe_flush,
    ct_fcnvt_norm_sh_pipe_if.slave bus
);

    // lz never exceeds FRAC_W-1, so this width always holds it.
    localparam int LZ_W = $clog2(FRAC_W + 1);

    // Keeps the top HLF_W bits. Masking (rather than extracting) leaves the
    // half field MSB-aligned, so one leading-zero counter and one shifter
    // serve both formats: for a non-zero half field, the zeros above its
    // leading one are the same count whether measured in the field or in the
    // masked FRAC_W-bit word.
    localparam logic [FRAC_W-1:0] HALF_MASK = {FRAC_W{1'b1}} << (FRAC_W - HLF_W);

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic              s1_vld_q,   s1_vld_d;
    logic [FRAC_W-1:0] s1_field_q, s1_field_d;
    logic [LZ_W-1:0]   s1_lz_q,    s1_lz_d;
    logic              s1_mode_q,  s1_mode_d;
    logic              s1_zero_q,  s1_zero_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    logic              s2_vld_q,   s2_vld_d;
    logic [FRAC_W:0]   out_f_q,    out_f_d;
    logic [CNT_W-1:0]  out_cnt_q,  out_cnt_d;
    logic              out_zero_q, out_zero_d;
    logic [TAG_W-1:0]  out_tag_q,  out_tag_d;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s2_adv;
    logic s1_adv;

    assign s2_adv = ~s2_vld_q | bus.out_rdy;
    assign s1_adv = ~s1_vld_q | s2_adv;

    // Reset wins over everything, so no input is offered as accepted then.
    assign bus.in_rdy = s1_adv & ~cpurst;

    // ---------------------------------------------------------------------
    // Stage 1 combinational: field select, zero detect, leading-zero count
    // ---------------------------------------------------------------------
    logic [FRAC_W-1:0] field_c;
    logic              zero_c;
    logic [LZ_W-1:0]   lz_c;

    // NOTE: every variable written in an always_comb gets a default on the
    // first lines; a path that leaves one unassigned would infer a latch.
    always_comb begin
        field_c = bus.in_mode ? (bus.in_src & HALF_MASK) : bus.in_src;
        zero_c  = (field_c == '0);
        lz_c    = '0;
        // Scan upward so the highest set bit is the last one to write lz_c.
        for (int i = 0; i < FRAC_W; i++) begin
            if (field_c[i]) begin
                lz_c = LZ_W'(FRAC_W - 1 - i);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2 combinational: normalising shift and exponent
    // ---------------------------------------------------------------------
    logic [FRAC_W:0]  f_c;
    logic [CNT_W-1:0] cnt_c;

    always_comb begin
        // Shifting by lz puts the leading one at FRAC_W-1; the appended zero
        // supplies the final +1 so it lands on bit FRAC_W.
        f_c   = {s1_field_q << s1_lz_q, 1'b0};
        // Done in CNT_W bits so the result wraps modulo 2^CNT_W.
        cnt_c = CNT_W'(0) - ((s1_mode_q ? CNT_W'(HLF_BIAS) : CNT_W'(SGL_BIAS))
                             + CNT_W'(s1_lz_q));
        if (s1_zero_q) begin
            f_c   = '0;
            cnt_c = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state: hold by default, advance when the stage ahead can take it
    // ---------------------------------------------------------------------
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_field_d = s1_field_q;
        s1_lz_d    = s1_lz_q;
        s1_mode_d  = s1_mode_q;
        s1_zero_d  = s1_zero_q;
        s1_tag_d   = s1_tag_q;

        s2_vld_d   = s2_vld_q;
        out_f_d    = out_f_q;
        out_cnt_d  = out_cnt_q;
        out_zero_d = out_zero_q;
        out_tag_d  = out_tag_q;

        if (s1_adv) begin
            s1_vld_d = bus.in_vld;
            if (bus.in_vld) begin
                s1_field_d = field_c;
                s1_lz_d    = lz_c;
                s1_mode_d  = bus.in_mode;
                s1_zero_d  = zero_c;
                s1_tag_d   = bus.in_tag;
            end
        end

        // Result data only changes when a real entry moves in, so the
        // outputs stay put while stalled and after the last entry drains.
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_f_d    = f_c;
                out_cnt_d  = cnt_c;
                out_zero_d = s1_zero_q;
                out_tag_d  = s1_tag_q;
            end
        end

        // Flush only kills validity; an input taken this cycle is dropped
        // because stage 1 comes out empty.
        if (pipe_flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            // The datapath is reset along with the valids so that out_f,
            // out_cnt, out_zero and out_tag read zero straight after reset.
            s1_vld_q   <= 1'b0;
            s1_field_q <= '0;
            s1_lz_q    <= '0;
            s1_mode_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_vld_q   <= 1'b0;
            out_f_q    <= '0;
            out_cnt_q  <= '0;
            out_zero_q <= 1'b0;
            out_tag_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_field_q <= s1_field_d;
            s1_lz_q    <= s1_lz_d;
            s1_mode_q  <= s1_mode_d;
            s1_zero_q  <= s1_zero_d;
            s1_tag_q   <= s1_tag_d;
            s2_vld_q   <= s2_vld_d;
            out_f_q    <= out_f_d;
            out_cnt_q  <= out_cnt_d;
            out_zero_q <= out_zero_d;
            out_tag_q  <= out_tag_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.out_vld  = s2_vld_q;
    assign bus.out_f    = out_f_q;
    assign bus.out_cnt  = out_cnt_q;
    assign bus.out_zero = out_zero_q;
    assign bus.out_tag  = out_tag_q;

endmodule : ct_fcnvt_norm_sh_pipe

// File: tb/tb_ct_fcnvt_norm_sh_pipe.sv
// ---------------------------------------------------------------------------
// tb_ct_fcnvt_norm_sh_pipe
//
// Directed and randomised stimulus for the fcnvt subnormal normaliser.
// Expected results come from an arithmetic reference (find the field's top
// set bit, move it to bit FRAC_W, exponent = -(bias + leading zeros)) and an
// in-order scoreboard of accepted entries.
// ---------------------------------------------------------------------------
module tb_ct_fcnvt_norm_sh_pipe;

    localparam int FRAC_W   = 23;
    localparam int HLF_W    = 10;
    localparam int SGL_BIAS = 127;
    localparam int HLF_BIAS = 15;
    localparam int CNT_W    = 12;
    localparam int TAG_W    = 4;

    typedef struct packed {
        logic [FRAC_W:0]  f;
        logic [CNT_W-1:0] cnt;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    ct_fcnvt_norm_sh_pipe_if #(.FRAC_W(FRAC_W), .CNT_W(CNT_W), .TAG_W(TAG_W)) bus ();

    ct_fcnvt_norm_sh_pipe #(
        .FRAC_W   (FRAC_W),
        .HLF_W    (HLF_W),
        .SGL_BIAS (SGL_BIAS),
        .HLF_BIAS (HLF_BIAS),
        .CNT_W    (CNT_W),
        .TAG_W    (TAG_W)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .pipe_flush     (flush),
        .bus            (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   n_out      = 0;
    logic last_acc   = 1'b0;
    exp_t sb_q[$];

    // Reference: normalise the selected field by plain arithmetic.
    function automatic exp_t model(logic mode, logic [FRAC_W-1:0] src, logic [TAG_W-1:0] tag);
        exp_t   e;
        longint v;
        int     w, p, lz, bias;
        e.tag = tag;
        w     = mode ? HLF_W : FRAC_W;
        bias  = mode ? HLF_BIAS : SGL_BIAS;
        v     = mode ? longint'(src >> (FRAC_W - HLF_W)) : longint'(src);
        if (v == 0) begin
            e.f    = '0;
            e.cnt  = '0;
            e.zero = 1'b1;
        end else begin
            p = 0;
            while ((v >> (p + 1)) != 0) p++;
            lz     = w - 1 - p;
            e.f    = (FRAC_W+1)'(v << (FRAC_W - p));
            e.cnt  = CNT_W'(-longint'(bias + lz));
            e.zero = 1'b0;
        end
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample the handshakes at the falling edge, update the
    // scoreboard, then return just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_vld && bus.out_rdy) begin
                n_out++;
                vectors++;
                assert (sb_q.size() > 0)
                else begin
                    miscompares++;
                    $error("FAIL sb_underflow: observed output tag %0h expected none", bus.out_tag);
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_tag",  64'(bus.out_tag),  64'(e.tag));
                    check("sb_f",    64'(bus.out_f),    64'(e.f));
                    check("sb_cnt",  64'(bus.out_cnt),  64'(e.cnt));
                    check("sb_zero", 64'(bus.out_zero), 64'(e.zero));
                end
            end
            last_acc = bus.in_vld && bus.in_rdy;
            if (flush) sb_q.delete();
            else if (last_acc) sb_q.push_back(model(bus.in_mode, bus.in_src, bus.in_tag));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic vld, logic mode, logic [FRAC_W-1:0] src, logic [TAG_W-1:0] tag);
        bus.in_vld  = vld;
        bus.in_mode = mode;
        bus.in_src  = src;
        bus.in_tag  = tag;
    endtask

    // Single entry through an empty pipe: result must show after two edges.
    task automatic directed(string name, logic mode, logic [FRAC_W-1:0] src,
                            logic [FRAC_W:0] ef, logic [CNT_W-1:0] ec, logic ez,
                            logic [TAG_W-1:0] tag);
        set_in(1'b1, mode, src, tag);
        tick();
        bus.in_vld = 1'b0;
        tick();
        check({name, "_vld"},  64'(bus.out_vld),  64'(1));
        check({name, "_f"},    64'(bus.out_f),    64'(ef));
        check({name, "_cnt"},  64'(bus.out_cnt),  64'(ec));
        check({name, "_zero"}, 64'(bus.out_zero), 64'(ez));
        check({name, "_tag"},  64'(bus.out_tag),  64'(tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [FRAC_W-1:0] bp_src  [1:5];
        logic              bp_mode [1:5];
        exp_t              bp_exp1;
        int                k, cyc, n_before;

        rst         = 1'b1;
        flush       = 1'b0;
        bus.out_rdy = 1'b1;
        set_in(1'b1, 1'b0, 23'h400000, 4'h3);

        // ---------------- reset state ----------------
        #1;
        tick();
        check("rst_in_rdy",   64'(bus.in_rdy),   64'(0));
        check("rst_out_vld",  64'(bus.out_vld),  64'(0));
        check("rst_out_f",    64'(bus.out_f),    64'(0));
        check("rst_out_cnt",  64'(bus.out_cnt),  64'(0));
        check("rst_out_zero", 64'(bus.out_zero), 64'(0));
        check("rst_out_tag",  64'(bus.out_tag),  64'(0));
        rst = 1'b0;
        bus.in_vld = 1'b0;
        tick();

        // ---------------- directed vectors ----------------
        directed("sgl_msb",  1'b0, 23'h400000, 24'h800000, 12'hF81, 1'b0, 4'h1);
        directed("sgl_lsb",  1'b0, 23'h000001, 24'h800000, 12'hF6B, 1'b0, 4'h2);
        directed("sgl_lz3",  1'b0, 23'h0C0000, 24'hC00000, 12'hF7E, 1'b0, 4'h3);
        directed("hlf_lsb",  1'b1, 23'h002000, 24'h800000, 12'hFE8, 1'b0, 4'h4);
        directed("hlf_zero", 1'b1, 23'h001FFF, 24'h000000, 12'h000, 1'b1, 4'h5);
        directed("sgl_zero", 1'b0, 23'h000000, 24'h000000, 12'h000, 1'b1, 4'h6);
        directed("hlf_msb",  1'b1, 23'h7FFFFF, 24'hFFC000, 12'hFF1, 1'b0, 4'h7);
        tick();
        tick();

        // ---------------- backpressure ----------------
        for (int i = 1; i <= 5; i++) begin
            bp_src[i]  = FRAC_W'($urandom >> $urandom_range(0, 20));
            bp_mode[i] = 1'($urandom_range(0, 1));
        end
        bp_exp1  = model(bp_mode[1], bp_src[1], 4'h1);
        n_before = n_out;
        k   = 1;
        cyc = 0;
        while (k <= 5 && cyc < 40) begin
            set_in(1'b1, bp_mode[k], bp_src[k], TAG_W'(k));
            bus.out_rdy = (cyc >= 4);
            #1;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_rdy",  64'(bus.in_rdy),  64'(0));
                check("bp_out_vld", 64'(bus.out_vld), 64'(1));
                check("bp_out_tag", 64'(bus.out_tag), 64'(1));
                check("bp_out_f",   64'(bus.out_f),   64'(bp_exp1.f));
                check("bp_out_cnt", 64'(bus.out_cnt), 64'(bp_exp1.cnt));
            end
            tick();
            if (last_acc) k++;
            cyc++;
        end
        check("bp_all_accepted", 64'(k), 64'(6));
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (4) tick();
        check("bp_out_count", 64'(n_out - n_before), 64'(5));
        check("bp_sb_empty",  64'(sb_q.size()),      64'(0));

        // ---------------- flush ----------------
        bus.out_rdy = 1'b0;
        set_in(1'b1, 1'b0, 23'h012345, 4'h6);
        tick();
        set_in(1'b1, 1'b1, 23'h123456, 4'h7);
        tick();
        check("fl_full_in_rdy", 64'(bus.in_rdy), 64'(0));
        flush       = 1'b1;
        bus.out_rdy = 1'b1;
        set_in(1'b1, 1'b0, 23'h000100, 4'h8);
        #1;
        check("fl_in_rdy", 64'(bus.in_rdy), 64'(1));
        tick();
        flush = 1'b0;
        check("fl_out_vld_cleared", 64'(bus.out_vld), 64'(0));
        set_in(1'b1, 1'b0, 23'h400000, 4'h9);
        tick();
        bus.in_vld = 1'b0;
        check("fl_dropped_gone", 64'(bus.out_vld), 64'(0));
        tick();
        check("fl_next_vld", 64'(bus.out_vld), 64'(1));
        check("fl_next_tag", 64'(bus.out_tag), 64'(9));
        check("fl_next_f",   64'(bus.out_f),   64'(24'h800000));
        tick();

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'($urandom_range(0, 1)), FRAC_W'($urandom), TAG_W'(i));
            tick();
        end
        rst = 1'b1;
        #1;
        check("mr_in_rdy_asserted", 64'(bus.in_rdy), 64'(0));
        tick();
        check("mr_out_vld",  64'(bus.out_vld),  64'(0));
        check("mr_out_f",    64'(bus.out_f),    64'(0));
        check("mr_out_cnt",  64'(bus.out_cnt),  64'(0));
        check("mr_out_zero", 64'(bus.out_zero), 64'(0));
        check("mr_out_tag",  64'(bus.out_tag),  64'(0));
        check("mr_in_rdy",   64'(bus.in_rdy),   64'(0));
        tick();
        rst = 1'b0;
        set_in(1'b1, 1'b0, 23'h0C0000, 4'hA);
        #1;
        check("mr_resume_in_rdy", 64'(bus.in_rdy), 64'(1));
        tick();
        bus.in_vld = 1'b0;
        tick();
        check("mr_resume_vld", 64'(bus.out_vld), 64'(1));
        check("mr_resume_tag", 64'(bus.out_tag), 64'(4'hA));
        check("mr_resume_f",   64'(bus.out_f),   64'(24'hC00000));
        check("mr_resume_cnt", 64'(bus.out_cnt), 64'(12'hF7E));
        tick();

        // ---------------- randomised traffic ----------------
        n_before = n_out;
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   FRAC_W'($urandom >> $urandom_range(0, 31)), TAG_W'($urandom));
            bus.out_rdy = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (4) tick();
        check("rnd_sb_empty", 64'(sb_q.size()), 64'(0));
        check("rnd_idle",     64'(bus.out_vld), 64'(0));
        vectors++;
        assert (n_out - n_before > 100)
        else begin
            miscompares++;
            $error("FAIL rnd_throughput: observed %0d results expected more than 100", n_out - n_before);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ct_fcnvt_norm_sh_pipe

// File: doc/ct_fcnvt_norm_sh_pipe.md
Name: ct_fcnvt_norm_sh_pipe

Overview:
- Parametrised, two-stage pipelined subnormal normaliser for the FP convert path (vfalu fcnvt).
- Finds the leading one of a subnormal fraction and shifts it into the MSB of the output. Also produces the signed unbiased exponent for the wider destination format.
- Supports single-precision and half-precision source fields, selected per transaction.
- Uses a valid/ready handshake with backpressure, flush, and a passthrough tag.

Parameters:
- FRAC_W, 23, source fraction field width; the half field is MSB-aligned inside it.
- HLF_W, 10, half-precision fraction width; must be <= FRAC_W.
- SGL_BIAS, 127, single-precision exponent bias.
- HLF_BIAS, 15, half-precision exponent bias.
- CNT_W, 12, output exponent width, two's complement.
- TAG_W, 4, sideband tag width.

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  synchronous active-high reset
- pipe_flush  in  1  kills all in-flight entries
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- in_mode  in  1  0 = single, 1 = half
- in_src  in  FRAC_W  fraction; half uses in_src[FRAC_W-1 -: HLF_W], lower bits ignored
- in_tag  in  TAG_W  sideband tag
- out_vld  out  1  result valid
- out_rdy  in  1  downstream ready
- out_f  out  FRAC_W+1  normalised fraction, leading one at the MSB
- out_cnt  out  CNT_W  unbiased exponent
- out_zero  out  1  selected field was all zero
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (cpurst=1 at a clock edge):
  - Stage valids s1_vld and s2_vld clear, so out_vld=0.
  - out_f=0, out_cnt=0, out_zero=0, out_tag=0.
  - Reset overrides the input handshake and flush in the same cycle.
- Handshake:
  - s2_adv = ~s2_vld | out_rdy.
  - s1_adv = ~s1_vld | s2_adv.
  - in_rdy = s1_adv (combinational); it is forced to 0 while cpurst=1.
  - A transfer happens when in_vld & in_rdy; the entry is captured into stage 1 at that edge.
- Latency:
  - 2 cycles from input acceptance to out_vld with no stall.
  - Throughput is 1 per cycle while out_rdy=1.
- Stage 1 (registered):
  - Select the field: single uses all FRAC_W bits; half uses the top HLF_W bits.
  - Compute lz = number of zeros above the first one within the field.
  - Register lz, field, mode, zero flag and tag.
  - When stalled (~s1_adv), stage 1 holds its contents.
- Stage 2 (registered, drives the outputs):
  - out_f = field shifted left by lz+1, placed into FRAC_W+1 bits. The leading one lands at bit FRAC_W and the vacated low bits are zero.
  - Half results are left-aligned to the same FRAC_W+1 width.
  - out_cnt = -(SGL_BIAS+lz) for single, -(HLF_BIAS+lz) for half, truncated to CNT_W bits.
  - If the field is zero: out_f=0, out_cnt=0, out_zero=1.
  - Outputs hold stable while out_vld & ~out_rdy.
- Flush: pipe_flush=1 clears s1_vld and s2_vld at the edge and drops any input accepted in that cycle. in_rdy stays per the formula.
- Simultaneous events: with stage 2 full and out_rdy=1, stage 2 drains, stage 1 moves into stage 2 and a new input enters stage 1, all in one edge.
- Invariant: no entry is duplicated or lost without a flush or reset.
- Width rule: out_cnt wraps modulo 2^CNT_W. This is a parameter-choice error, not a runtime condition.

Test Plan:
- Single, in_src=23'h400000 -> two cycles later out_f=24'h800000, out_cnt=12'hF81, out_zero=0.
- Single, in_src=23'h000001 -> out_f=24'h800000, out_cnt=12'hF6B (-149). Single, in_src=23'h0C0000 -> lz=3, out_f=24'hC00000, out_cnt=12'hF7E.
- Half, in_src=23'h002000 (field 10'b0000000001) -> out_f=24'h800000, out_cnt=12'hFE8 (-24). Half, in_src=23'h001FFF (field zero) -> out_f=0, out_cnt=0, out_zero=1.
- Backpressure: stream tags 1..5 with out_rdy=0 for 4 cycles:
  - in_rdy drops after two entries are held.
  - out_f, out_cnt and out_tag stay stable while stalled.
  - After release, tags emerge 1..5 in order with none lost or duplicated.
- Flush with both stages full -> out_vld=0 next cycle. An input accepted in the flush cycle never appears; the next accepted input appears 2 cycles later.
- Assert cpurst mid-stream -> out_vld=0 and all outputs 0 after the edge, in_rdy=0 during reset; normal operation resumes the cycle after deassertion.
